skid_pipeline: RTL and testbench
================================

// Module: skid_pipeline
// PURPOSE
//  Chain of registered-ready (skid) stages on a valid/ready stream.
//  Complements the forward register pipeline, which registers data/valid
//  but leaves WR_DATA_READY a combinational chain from RD_DATA_READY.
//  This block registers the backward ready path per stage, so a deep
//  pipeline meets timing on both directions. Drop-in between any two
//  valid/ready interfaces.
// PARAMETERS
//  C_DEPTH  2   number of skid stages; 0 = combinational passthrough
//  C_WIDTH  10  data width in bits
// PORTS
//  CLK            in   1        clock
//  RST_N          in   1        reset; asynchronous assert, active-low
//  WR_DATA        in   C_WIDTH  upstream data
//  WR_DATA_VALID  in   1        upstream valid
//  WR_DATA_READY  out  1        registered ready to upstream
//  RD_DATA        out  C_WIDTH  downstream data (stage C_DEPTH main reg)
//  RD_DATA_VALID  out  1        downstream valid
//  RD_DATA_READY  in   1        downstream ready
// BEHAVIOUR
//  - Transfer on a port = VALID & READY at a rising CLK edge.
//  - Reset (RST_N=0, async): every stage EMPTY, all data regs 0, ready regs 0.
//    WR_DATA_READY=0, RD_DATA_VALID=0, RD_DATA=0 while RST_N=0.
//    WR_DATA_READY rises at the first CLK edge after RST_N deasserts.
//  - Per stage: main reg M, skid reg S, registered rReady, 3-state FSM:
//    EMPTY: wr -> BUSY, M<=in.
//    BUSY : wr&rd -> BUSY, M<=in; wr&~rd -> FULL, S<=in; ~wr&rd -> EMPTY.
//    FULL : rd -> BUSY, M<=S; ~rd -> FULL. No write possible (rReady=0).
//    wr = in_valid & rReady; rd = out_valid & out_ready.
//    out_valid = (state != EMPTY); out_data = M.
//    rReady <= (next_state != FULL); exact, no early deassert.
//  - Stage k out feeds stage k+1 in; stage 1 in = WR_*, stage C_DEPTH out = RD_*.
//  - Latency: C_DEPTH cycles empty-to-output. Throughput: 1 word/cycle
//    with RD_DATA_READY held high.
//  - Capacity: 2*C_DEPTH words; WR_DATA_READY low one cycle after the
//    cycle that fills stage 1.
//  - No word is dropped, duplicated or reordered under any valid/ready
//    pattern; WR_DATA accepted in a cycle RD_DATA_READY deasserts goes to S.
//  - Reset mid-operation: all in-flight words discarded, same as power-up.
//  - C_DEPTH=0: WR_DATA_READY=RD_DATA_READY, RD_*=WR_* combinationally;
//    RST_N unused.
//  - Data regs enabled only on the transitions above (no gratuitous toggles).
// STRUCTURE
//  - Package pipeline_pkg: typedef enum logic [1:0]
//    {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_t.
//  - Sub-module skid_stage (C_WIDTH): one FSM + M/S/rReady regs;
//    skid_pipeline is a generate chain of C_DEPTH instances.
// TESTING
//  - Reset: RST_N=0 mid-clock -> RD_DATA_VALID=0, WR_DATA_READY=0 at once;
//    WR_DATA_READY=1 one edge after release.
//  - Streaming C_DEPTH=2: words 1..16 back-to-back, RD_DATA_READY=1 ->
//    word 1 out 2 cycles after accept, then 1/cycle, in order.
//  - Backpressure C_DEPTH=2: RD_DATA_READY=0, push continuously ->
//    exactly 4 words accepted, then WR_DATA_READY=0; release -> 4 out in order.
//  - Single-cycle stalls: RD_DATA_READY toggles every cycle with continuous
//    valid input -> no loss/duplication, scoreboard matches.
//  - Reset mid-stream with 3 words buffered -> none emerge after reset;
//    next word pushed emerges first.
//  - C_DEPTH=0: WR_DATA=0x2A1, valid=1 -> RD_DATA=0x2A1, RD_DATA_VALID=1
//    same cycle; ready passes through.

Source files
------------

// File: rtl/pipeline_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipeline_pkg
// Purpose  : Shared types for the registered-ready (skid) pipeline.
//            Each stage is described by a small three-state machine:
//              SKID_EMPTY - neither the main nor the skid register holds a word
//              SKID_BUSY  - main register holds the oldest word, skid is free
//              SKID_FULL  - main holds the oldest word, skid holds the newer one
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Words a single stage can hold (main + skid).
  localparam int unsigned C_SKID_WORDS_PER_STAGE = 2;

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/skid_stage.sv
//------------------------------------------------------------------------------
// Module   : skid_stage
// Purpose  : One registered-ready skid stage on a valid/ready stream.
//            The ready returned upstream is a flop, so the backward path is
//            cut at every stage. A word that arrives in the same cycle the
//            downstream side stalls is parked in the skid register; the
//            stage then drops ready until the skid word has moved to main.
// Ports    :
//   clk          in   1        clock
//   rst_n        in   1        asynchronous active-low reset
//   i_in_data    in   C_WIDTH  upstream data
//   i_in_valid   in   1        upstream valid
//   o_in_ready   out  1        registered ready to upstream
//   o_out_data   out  C_WIDTH  downstream data (main register)
//   o_out_valid  out  1        downstream valid (stage not empty)
//   i_out_ready  in   1        downstream ready
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skid_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned C_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [C_WIDTH-1:0] i_in_data,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  output logic [C_WIDTH-1:0] o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready
);

  skid_state_t        r_state;
  logic [C_WIDTH-1:0] r_main;
  logic [C_WIDTH-1:0] r_skid;
  logic               r_ready;
  logic               r_valid;

  logic               w_wr;
  logic               w_rd;

  // r_ready is zero whenever the stage is FULL, so w_wr can only fire in
  // EMPTY or BUSY. r_valid mirrors (r_state != SKID_EMPTY).
  assign w_wr = i_in_valid & r_ready;
  assign w_rd = r_valid & i_out_ready;

  assign o_in_ready  = r_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_main;

  // State, data registers and the registered handshake outputs all advance
  // together. Ready/valid are loaded with the value that matches the state
  // being entered, so they never lead or lag the state by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SKID_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          r_ready <= 1'b1;
          if (w_wr) begin
            r_state <= SKID_BUSY;
            r_main  <= i_in_data;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end

        SKID_BUSY: begin
          if (w_wr && w_rd) begin
            // Old word leaves while the new one takes its place.
            r_main  <= i_in_data;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
          end else if (w_wr) begin
            // Downstream stalled in the same cycle: park the new word.
            r_state <= SKID_FULL;
            r_skid  <= i_in_data;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_rd) begin
            r_state <= SKID_EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
          end else begin
            r_ready <= 1'b1;
            r_valid <= 1'b1;
          end
        end

        SKID_FULL: begin
          r_valid <= 1'b1;
          if (w_rd) begin
            // Skid word becomes the head; skid reg is left untouched.
            r_state <= SKID_BUSY;
            r_main  <= r_skid;
            r_ready <= 1'b1;
          end else begin
            r_ready <= 1'b0;
          end
        end

        default: begin
          r_state <= SKID_EMPTY;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : skid_stage

`default_nettype wire

// File: rtl/skid_pipeline.sv
//------------------------------------------------------------------------------
// Module   : skid_pipeline
// Purpose  : Chain of C_DEPTH registered-ready skid stages between two
//            valid/ready interfaces. Both the forward (data/valid) and the
//            backward (ready) paths are registered in every stage.
//            Capacity is two words per stage; empty-to-output latency is
//            C_DEPTH cycles; throughput is one word per cycle.
//            C_DEPTH = 0 degenerates to a combinational passthrough.
// Ports    :
//   CLK            in   1        clock
//   RST_N          in   1        asynchronous active-low reset
//   WR_DATA        in   C_WIDTH  upstream data
//   WR_DATA_VALID  in   1        upstream valid
//   WR_DATA_READY  out  1        registered ready to upstream
//   RD_DATA        out  C_WIDTH  downstream data
//   RD_DATA_VALID  out  1        downstream valid
//   RD_DATA_READY  in   1        downstream ready
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skid_pipeline
  import pipeline_pkg::*;
#(
  parameter int unsigned C_DEPTH = 2,
  parameter int unsigned C_WIDTH = 10
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [C_WIDTH-1:0] WR_DATA,
  input  logic               WR_DATA_VALID,
  output logic               WR_DATA_READY,
  output logic [C_WIDTH-1:0] RD_DATA,
  output logic               RD_DATA_VALID,
  input  logic               RD_DATA_READY
);

  generate
    if (C_DEPTH == 0) begin : g_bypass
      // No storage: the clock and reset have nothing to drive.
      logic w_unused;
      assign w_unused = CLK ^ RST_N;

      assign RD_DATA       = WR_DATA;
      assign RD_DATA_VALID = WR_DATA_VALID;
      assign WR_DATA_READY = RD_DATA_READY;
    end else begin : g_pipe
      // Link k sits between stage k-1 and stage k; link 0 is the write port
      // and link C_DEPTH is the read port.
      logic [C_WIDTH-1:0] w_data  [C_DEPTH+1];
      logic [C_DEPTH:0]   w_valid;
      logic [C_DEPTH:0]   w_ready;

      assign w_data[0]        = WR_DATA;
      assign w_valid[0]       = WR_DATA_VALID;
      assign WR_DATA_READY    = w_ready[0];

      assign RD_DATA          = w_data[C_DEPTH];
      assign RD_DATA_VALID    = w_valid[C_DEPTH];
      assign w_ready[C_DEPTH] = RD_DATA_READY;

      for (genvar k = 0; k < C_DEPTH; k++) begin : g_stage
        skid_stage #(
          .C_WIDTH (C_WIDTH)
        ) u_stage (
          .clk         (CLK),
          .rst_n       (RST_N),
          .i_in_data   (w_data[k]),
          .i_in_valid  (w_valid[k]),
          .o_in_ready  (w_ready[k]),
          .o_out_data  (w_data[k+1]),
          .o_out_valid (w_valid[k+1]),
          .i_out_ready (w_ready[k+1])
        );
      end
    end
  endgenerate

endmodule : skid_pipeline

`default_nettype wire

// File: tb/tb_skid_pipeline.sv
//------------------------------------------------------------------------------
// Module   : tb_skid_pipeline
// Purpose  : Self-checking bench for skid_pipeline (C_DEPTH=2 and C_DEPTH=0).
//            A queue-per-stage model predicts ready/valid/data every cycle;
//            directed tests add literal expectations on ordering, latency,
//            capacity and reset behaviour.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_skid_pipeline;

  localparam int C_W = 10;
  localparam int C_D = 2;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [C_W-1:0] WR_DATA = '0;
  logic           WR_DATA_VALID = 1'b0;
  logic           WR_DATA_READY;
  logic [C_W-1:0] RD_DATA;
  logic           RD_DATA_VALID;
  logic           RD_DATA_READY = 1'b0;

  logic [C_W-1:0] z_wr_data = '0;
  logic           z_wr_valid = 1'b0;
  logic           z_wr_ready;
  logic [C_W-1:0] z_rd_data;
  logic           z_rd_valid;
  logic           z_rd_ready = 1'b0;

  always #5 CLK = ~CLK;

  skid_pipeline #(.C_DEPTH(C_D), .C_WIDTH(C_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .WR_DATA       (WR_DATA),
    .WR_DATA_VALID (WR_DATA_VALID),
    .WR_DATA_READY (WR_DATA_READY),
    .RD_DATA       (RD_DATA),
    .RD_DATA_VALID (RD_DATA_VALID),
    .RD_DATA_READY (RD_DATA_READY)
  );

  skid_pipeline #(.C_DEPTH(0), .C_WIDTH(C_W)) dut0 (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .WR_DATA       (z_wr_data),
    .WR_DATA_VALID (z_wr_valid),
    .WR_DATA_READY (z_wr_ready),
    .RD_DATA       (z_rd_data),
    .RD_DATA_VALID (z_rd_valid),
    .RD_DATA_READY (z_rd_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: each stage is a queue of at most two words -------
  logic [C_W-1:0] mq [0:C_D-1][$];
  bit             mrdy [0:C_D-1];
  bit             m_iv;
  bit             m_or;
  bit             m_wr [0:C_D-1];
  bit             m_rd [0:C_D-1];
  logic [C_W-1:0] m_in [0:C_D-1];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < C_D; k++) begin
        mq[k].delete();
        mrdy[k] = 1'b0;
      end
    end else begin
      // Decide every transfer from the pre-edge picture first.
      for (int k = 0; k < C_D; k++) begin
        if (k == 0) begin
          m_iv    = WR_DATA_VALID;
          m_in[k] = WR_DATA;
        end else begin
          m_iv    = (mq[k-1].size() > 0);
          m_in[k] = m_iv ? mq[k-1][0] : '0;
        end
        if (k == C_D - 1) m_or = RD_DATA_READY;
        else              m_or = mrdy[k+1];
        m_wr[k] = m_iv && mrdy[k];
        m_rd[k] = (mq[k].size() > 0) && m_or;
      end
      for (int k = 0; k < C_D; k++) begin
        if (m_rd[k]) void'(mq[k].pop_front());
        if (m_wr[k]) mq[k].push_back(m_in[k]);
        mrdy[k] = (mq[k].size() < 2);
      end
    end
  end

  always @(negedge CLK) begin
    chk("cyc_wr_ready", {31'd0, WR_DATA_READY}, {31'd0, mrdy[0]});
    chk("cyc_rd_valid", {31'd0, RD_DATA_VALID}, {31'd0, (mq[C_D-1].size() > 0)});
    if (mq[C_D-1].size() > 0)
      chk("cyc_rd_data", {22'd0, RD_DATA}, {22'd0, mq[C_D-1][0]});
  end

  // ---------------- driver ---------------------------------------------------
  int             cyc_n = 0;
  int             n_acc = 0;
  int             t_acc0 = -1;
  int             t_out0 = -1;
  int             t_outn = -1;
  logic [C_W-1:0] out_q [$];

  task automatic clear_log();
    n_acc  = 0;
    t_acc0 = -1;
    t_out0 = -1;
    t_outn = -1;
    out_q.delete();
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cyc(input logic v, input logic r);
    bit acc;
    WR_DATA_VALID = v;
    RD_DATA_READY = r;
    @(posedge CLK);
    cyc_n++;
    acc = WR_DATA_VALID && WR_DATA_READY;
    if (acc) begin
      if (t_acc0 < 0) t_acc0 = cyc_n;
      n_acc++;
    end
    if (RD_DATA_VALID && RD_DATA_READY) begin
      out_q.push_back(RD_DATA);
      if (t_out0 < 0) t_out0 = cyc_n;
      t_outn = cyc_n;
    end
    #1;
    if (acc) WR_DATA = WR_DATA + 1'b1;
  endtask

  initial begin
    // ---- power-up reset ----
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_wr_ready", {31'd0, WR_DATA_READY}, 32'd0);
    chk("rst_rd_valid", {31'd0, RD_DATA_VALID}, 32'd0);
    chk("rst_rd_data", {22'd0, RD_DATA}, 32'd0);
    #1 RST_N = 1'b1;
    #1 chk("rel_wr_ready_pre_edge", {31'd0, WR_DATA_READY}, 32'd0);
    @(posedge CLK);
    #1 chk("rel_wr_ready_post_edge", {31'd0, WR_DATA_READY}, 32'd1);

    // ---- streaming 1..16 ----
    clear_log();
    WR_DATA = 10'd1;
    for (int i = 0; i < 40 && n_acc < 16; i++) cyc(1'b1, 1'b1);
    chk("stream_accepts", n_acc, 32'd16);
    for (int i = 0; i < 20 && out_q.size() < 16; i++) cyc(1'b0, 1'b1);
    chk("stream_out_count", out_q.size(), 32'd16);
    chk("stream_latency", t_out0 - t_acc0, 32'd2);
    chk("stream_rate", t_outn - t_out0, 32'd15);
    for (int i = 0; i < out_q.size(); i++)
      chk("stream_order", {22'd0, out_q[i]}, i + 1);

    // ---- backpressure: capacity 4 ----
    clear_log();
    WR_DATA = 10'h101;
    repeat (8) cyc(1'b1, 1'b0);
    chk("bp_accepts", n_acc, 32'd4);
    chk("bp_wr_ready", {31'd0, WR_DATA_READY}, 32'd0);
    chk("bp_rd_valid", {31'd0, RD_DATA_VALID}, 32'd1);
    repeat (8) cyc(1'b0, 1'b1);
    chk("bp_out_count", out_q.size(), 32'd4);
    for (int i = 0; i < out_q.size(); i++)
      chk("bp_order", {22'd0, out_q[i]}, 32'h101 + i);

    // ---- single-cycle stalls ----
    clear_log();
    WR_DATA = 10'h200;
    for (int i = 0; i < 40; i++) cyc(1'b1, i[0]);
    repeat (12) cyc(1'b0, 1'b1);
    chk("tog_accepts_nonzero", {31'd0, (n_acc > 0)}, 32'd1);
    chk("tog_out_count", out_q.size(), n_acc);
    for (int i = 0; i < out_q.size(); i++)
      chk("tog_order", {22'd0, out_q[i]}, 32'h200 + i);

    // ---- reset mid-stream with 3 words buffered ----
    clear_log();
    WR_DATA = 10'h300;
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("mid_buffered", n_acc, 32'd3);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_rd_valid", {31'd0, RD_DATA_VALID}, 32'd0);
    chk("mid_rst_wr_ready", {31'd0, WR_DATA_READY}, 32'd0);
    chk("mid_rst_rd_data", {22'd0, RD_DATA}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("mid_rel_wr_ready", {31'd0, WR_DATA_READY}, 32'd1);
    clear_log();
    WR_DATA = 10'h0AB;
    cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    chk("mid_out_count", out_q.size(), 32'd1);
    if (out_q.size() > 0) chk("mid_first_word", {22'd0, out_q[0]}, 32'h0AB);

    // ---- C_DEPTH = 0 passthrough ----
    z_wr_data  = 10'h2A1;
    z_wr_valid = 1'b1;
    z_rd_ready = 1'b1;
    #1;
    chk("d0_rd_data", {22'd0, z_rd_data}, 32'h2A1);
    chk("d0_rd_valid", {31'd0, z_rd_valid}, 32'd1);
    chk("d0_wr_ready_hi", {31'd0, z_wr_ready}, 32'd1);
    z_rd_ready = 1'b0;
    #1 chk("d0_wr_ready_lo", {31'd0, z_wr_ready}, 32'd0);
    z_wr_valid = 1'b0;
    #1 chk("d0_rd_valid_lo", {31'd0, z_rd_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_skid_pipeline

`default_nettype wire
